opb_register_ppc2simulink: RTL and testbench

//   OPB slave holding a 32-bit control register written by the PowerPC and driven

---
 rtl/opb_register_ppc2simulink.sv | 123 ++++++++++++
 tb/tb_opb_register_ppc2simulink.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave holding a PPC-written 32-bit control word that drives fabric logic, with a
// one-cycle update strobe and a read-only count of completed data writes.
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_8800,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_88FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam bit CFG_OK = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && ($bits(C_FAMILY) > 0);

  state_t      state;
  state_t      state_next;
  logic [31:0] data_q;
  logic [31:0] data_next;
  logic [15:0] wr_count;
  logic [31:0] rd_word_q;
  logic        valid_q;
  logic [31:0] offset;
  logic [1:0]  reg_sel;
  logic [31:0] sel_word;
  logic        hit;
  logic        take;
  logic        data_wr;
  logic        unused_ok;

  assign offset  = OPB_ABus - C_BASEADDR;
  assign reg_sel = offset[3:2];
  assign hit     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign take    = (state == IDLE) && hit;
  assign data_wr = take && !OPB_RNW && (reg_sel == 2'd0);

  assign unused_ok = &{1'b0, OPB_seqAddr, offset[31:4], offset[1:0], CFG_OK};

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A transfer always occupies exactly one ACK cycle, so back-to-back requests pace at 1 per 2 cycles.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = hit ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Sl_xferAck = 1'b0;
    Sl_DBus    = '0;
    if (state == ACK) begin
      Sl_xferAck = 1'b1;
      Sl_DBus    = rd_word_q;
    end
  end

  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = data_q;
  assign user_data_valid = valid_q;

  always_comb begin
    sel_word = 32'h0;
    case (reg_sel)
      2'd0:    sel_word = data_q;
      2'd1:    sel_word = {16'h0000, wr_count};
      default: sel_word = 32'h0;
    endcase
  end

  // OPB is big-endian: BE[0] and DBus[0:7] carry the most significant byte of the word.
  always_comb begin
    data_next = data_q;
    for (int i = 0; i < 4; i++) begin
      if (OPB_BE[i]) begin
        data_next[31-8*i -: 8] = OPB_DBus[8*i +: 8];
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q    <= C_RESET_VAL;
      wr_count  <= 16'h0000;
      rd_word_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      valid_q   <= data_wr;
      rd_word_q <= (take && OPB_RNW) ? sel_word : 32'h0;
      if (data_wr) begin
        data_q   <= data_next;
        wr_count <= wr_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed bench for opb_register_ppc2simulink: vector table of single transfers plus
// hand-written sequences for back-to-back, out-of-window and reset-during-transfer cases.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE  = 32'h0100_8800;
  localparam logic [31:0] HIGH  = 32'h0100_88FF;
  localparam logic [31:0] RSTV  = 32'h1357_9BDF;
  localparam int          LIMIT = 4;

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [0:3]  be;
    logic [31:0] wdata;
    logic        expAck;
    logic [31:0] expRdata;
    logic        expValid;
    logic [31:0] expUser;
  } vec_t;

  logic        clock;
  logic        OPB_Rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  opb_register_ppc2simulink #(
    .C_BASEADDR(BASE),
    .C_HIGHADDR(HIGH),
    .C_RESET_VAL(RSTV)
  ) dut (
    .OPB_Clk(clock),
    .OPB_Rst_n(OPB_Rst_n),
    .OPB_ABus(OPB_ABus),
    .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus),
    .OPB_RNW(OPB_RNW),
    .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus),
    .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup),
    .user_data_out(user_data_out),
    .user_data_valid(user_data_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                        input logic [31:0] wdata, input logic expAck, input logic [31:0] expRdata,
                        input logic expValid, input logic [31:0] expUser);
    vec_t v;
    v.addr = addr; v.rnw = rnw; v.be = be; v.wdata = wdata;
    v.expAck = expAck; v.expRdata = expRdata; v.expValid = expValid; v.expUser = expUser;
    vecs.push_back(v);
  endtask

  // One OPB transfer; ackLat is the number of edges until Sl_xferAck, 0 if none within LIMIT.
  task automatic applyStimulus(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                               input logic [31:0] wdata, output int ackLat,
                               output logic [31:0] rdata, output logic validAtAck);
    ackLat = 0;
    rdata = 32'h0;
    validAtAck = 1'b0;
    @(negedge clock);
    OPB_ABus = addr;
    OPB_RNW = rnw;
    OPB_BE = be;
    OPB_DBus = wdata;
    OPB_select = 1'b1;
    for (int c = 0; c < LIMIT; c++) begin
      @(posedge clock);
      #1;
      if (Sl_xferAck) begin
        ackLat = c + 1;
        rdata = Sl_DBus;
        validAtAck = user_data_valid;
        break;
      end
    end
    @(negedge clock);
    OPB_select = 1'b0;
    OPB_ABus = '0;
    OPB_BE = '0;
    OPB_DBus = '0;
    OPB_RNW = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        vld;
    int          pulses;
    string       tag;

    OPB_Rst_n = 1'b0;
    OPB_ABus = '0;
    OPB_BE = '0;
    OPB_DBus = '0;
    OPB_RNW = 1'b0;
    OPB_select = 1'b0;
    OPB_seqAddr = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_ack", {31'b0, Sl_xferAck}, 32'h0);
    checkOutput("reset_dbus", Sl_DBus, 32'h0);
    checkOutput("reset_user", user_data_out, RSTV);
    checkOutput("reset_valid", {31'b0, user_data_valid}, 32'h0);
    checkOutput("reset_consts", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    @(negedge clock);
    OPB_Rst_n = 1'b1;

    addVec(BASE + 32'h0,  1'b1, 4'b1111, 32'h0,          1'b1, RSTV,          1'b0, RSTV);
    addVec(BASE + 32'h4,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h0,         1'b0, RSTV);
    addVec(BASE + 32'h0,  1'b0, 4'b1111, 32'hDEADBEEF,   1'b1, 32'h0,         1'b1, 32'hDEADBEEF);
    addVec(BASE + 32'h0,  1'b1, 4'b1111, 32'h0,          1'b1, 32'hDEADBEEF,  1'b0, 32'hDEADBEEF);
    addVec(BASE + 32'h0,  1'b0, 4'b0101, 32'h11223344,   1'b1, 32'h0,         1'b1, 32'hDE22BE44);
    addVec(BASE + 32'h4,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h2,         1'b0, 32'hDE22BE44);
    addVec(BASE + 32'h0,  1'b0, 4'b0000, 32'hCAFEF00D,   1'b1, 32'h0,         1'b1, 32'hDE22BE44);
    addVec(BASE + 32'h4,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h3,         1'b0, 32'hDE22BE44);
    addVec(BASE + 32'h8,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h0,         1'b0, 32'hDE22BE44);
    addVec(BASE + 32'h4,  1'b0, 4'b1111, 32'hFFFFFFFF,   1'b1, 32'h0,         1'b0, 32'hDE22BE44);
    addVec(BASE + 32'hC,  1'b0, 4'b1111, 32'h12345678,   1'b1, 32'h0,         1'b0, 32'hDE22BE44);
    addVec(BASE + 32'h4,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h3,         1'b0, 32'hDE22BE44);
    addVec(BASE + 32'h0,  1'b0, 4'b1000, 32'hA5A5A5A5,   1'b1, 32'h0,         1'b1, 32'hA522BE44);
    addVec(BASE + 32'h0,  1'b1, 4'b0000, 32'h0,          1'b1, 32'hA522BE44,  1'b0, 32'hA522BE44);
    addVec(BASE + 32'hC,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h0,         1'b0, 32'hA522BE44);
    addVec(HIGH + 32'h4,  1'b1, 4'b1111, 32'h0,          1'b0, 32'h0,         1'b0, 32'hA522BE44);
    addVec(BASE - 32'h4,  1'b0, 4'b1111, 32'h0BADF00D,   1'b0, 32'h0,         1'b0, 32'hA522BE44);
    addVec(HIGH - 32'h3,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h0,         1'b0, 32'hA522BE44);
    addVec(BASE + 32'h4,  1'b1, 4'b1111, 32'h0,          1'b1, 32'h4,         1'b0, 32'hA522BE44);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].rnw, vecs[i].be, vecs[i].wdata, lat, rd, vld);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, "_ack"}, lat, vecs[i].expAck ? 32'd1 : 32'd0);
      if (vecs[i].expAck && vecs[i].rnw)
        checkOutput({tag, "_rdata"}, rd, vecs[i].expRdata);
      checkOutput({tag, "_valid"}, {31'b0, vld}, {31'b0, vecs[i].expValid});
      @(posedge clock);
      #1;
      checkOutput({tag, "_idle"}, {30'b0, Sl_xferAck, user_data_valid}, 32'h0);
      checkOutput({tag, "_user"}, user_data_out, vecs[i].expUser);
    end

    // Back-to-back reads with select held: ack on every other edge
    @(negedge clock);
    OPB_ABus = BASE + 32'h4;
    OPB_RNW = 1'b1;
    OPB_BE = 4'b1111;
    OPB_select = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("b2b_ack%0d", c), {31'b0, Sl_xferAck}, (c % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b_dbus%0d", c), Sl_DBus, (c % 2 == 0) ? 32'd4 : 32'd0);
    end
    @(negedge clock);
    OPB_select = 1'b0;

    // Out-of-window select held for 16 cycles
    OPB_ABus = HIGH + 32'h4;
    OPB_select = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("oow_ack%0d", c), {31'b0, Sl_xferAck}, 32'h0);
      checkOutput($sformatf("oow_dbus%0d", c), Sl_DBus, 32'h0);
    end
    @(negedge clock);
    OPB_select = 1'b0;
    OPB_RNW = 1'b0;

    // Reset asserted in the middle of the ACK cycle of a data write
    OPB_ABus = BASE;
    OPB_BE = 4'b1111;
    OPB_DBus = 32'h55667788;
    OPB_select = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rst_mid_ack_before", {31'b0, Sl_xferAck}, 32'h1);
    #1;
    OPB_Rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ack_after", {31'b0, Sl_xferAck}, 32'h0);
    checkOutput("rst_mid_user", user_data_out, RSTV);
    checkOutput("rst_mid_valid", {31'b0, user_data_valid}, 32'h0);
    checkOutput("rst_mid_dbus", Sl_DBus, 32'h0);
    @(negedge clock);
    OPB_select = 1'b0;
    @(negedge clock);
    OPB_Rst_n = 1'b1;

    // Reset asserted before the edge that would commit a write
    @(negedge clock);
    OPB_DBus = 32'h99999999;
    OPB_select = 1'b1;
    #2;
    OPB_Rst_n = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst_pend_ack", {31'b0, Sl_xferAck}, 32'h0);
    checkOutput("rst_pend_user", user_data_out, RSTV);
    @(negedge clock);
    OPB_select = 1'b0;
    OPB_DBus = '0;
    OPB_BE = '0;
    OPB_ABus = '0;
    @(negedge clock);
    OPB_Rst_n = 1'b1;

    applyStimulus(BASE + 32'h4, 1'b1, 4'b1111, 32'h0, lat, rd, vld);
    checkOutput("post_rst_status", rd, 32'h0);
    applyStimulus(BASE, 1'b1, 4'b1111, 32'h0, lat, rd, vld);
    checkOutput("post_rst_data", rd, RSTV);

    // 300 back-to-back data writes with select held
    pulses = 0;
    @(negedge clock);
    OPB_ABus = BASE;
    OPB_RNW = 1'b0;
    OPB_BE = 4'b1111;
    OPB_DBus = 32'h0BADCAFE;
    OPB_select = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clock);
      #1;
      if (user_data_valid) pulses++;
    end
    @(negedge clock);
    OPB_select = 1'b0;
    checkOutput("burst_pulses", pulses, 32'd300);
    checkOutput("burst_user", user_data_out, 32'h0BADCAFE);
    applyStimulus(BASE + 32'h4, 1'b1, 4'b1111, 32'h0, lat, rd, vld);
    checkOutput("burst_status", rd, 32'd300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
